axis_fifo_drain_ctrl: RTL and testbench

AXIS_FIFO_DRAIN_CTRL -- requirements
Module: axis_fifo_drain_ctrl

---
 rtl/axis_fifo_drain_ctrl.sv | 108 ++++++++++
 tb/tb_axis_fifo_drain_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_fifo_drain_ctrl.sv
// Drains one packet of burst_len words from a registered-read FIFO onto an
// AXI-Stream master port: one FIFO pop per beat, data held until accepted.
module axis_fifo_drain_ctrl #(
   parameter int FIFO_DATA_WIDTH = 32,
   parameter int LEN_WIDTH       = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [LEN_WIDTH-1:0]       burst_len,
   input  logic                       abort,
   input  logic                       fifo_empty,
   output logic                       fifo_pop,
   input  logic [FIFO_DATA_WIDTH-1:0] fifo_data,
   output logic                       m_axis_tvalid,
   input  logic                       m_axis_tready,
   output logic [FIFO_DATA_WIDTH-1:0] m_axis_tdata,
   output logic                       m_axis_tlast,
   output logic                       busy,
   output logic                       done,
   output logic                       aborted
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_FIFO,
      S_POP,
      S_LOAD,
      S_SEND,
      S_DONE
   } state_t;

   localparam logic [LEN_WIDTH:0] BEAT_ONE = {{LEN_WIDTH{1'b0}}, 1'b1};

   state_t                     state, state_nxt;
   logic [LEN_WIDTH:0]         beats_left, beats_left_nxt;
   logic [FIFO_DATA_WIDTH-1:0] tdata_nxt;
   logic                       aborted_nxt;
   logic                       last_beat;

   assign last_beat = (beats_left == BEAT_ONE);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         beats_left   <= '0;
         m_axis_tdata <= '0;
         aborted      <= 1'b0;
      end else begin
         state        <= state_nxt;
         beats_left   <= beats_left_nxt;
         m_axis_tdata <= tdata_nxt;
         aborted      <= aborted_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      beats_left_nxt = beats_left;
      tdata_nxt      = m_axis_tdata;
      aborted_nxt    = 1'b0;
      case (state)
         S_IDLE: begin
            if (start && (burst_len != '0)) begin
               beats_left_nxt = {1'b0, burst_len};
               state_nxt      = S_WAIT_FIFO;
            end
         end
         S_WAIT_FIFO: begin
            if (abort) begin
               aborted_nxt    = 1'b1;
               beats_left_nxt = '0;
               state_nxt      = S_IDLE;
            end else if (!fifo_empty) begin
               state_nxt = S_POP;
            end
         end
         S_POP:  state_nxt = S_LOAD;
         // fifo_data is the registered read of the pop issued last cycle
         S_LOAD: begin
            tdata_nxt = fifo_data;
            state_nxt = S_SEND;
         end
         S_SEND: begin
            if (m_axis_tready) begin
               beats_left_nxt = beats_left - BEAT_ONE;
               if (last_beat)
                  state_nxt = S_DONE;
               // WAIT_FIFO takes zero cycles when the next word is already there
               else if (!fifo_empty)
                  state_nxt = S_POP;
               else
                  state_nxt = S_WAIT_FIFO;
            end
         end
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // outputs decode from state and registered beat count only
   assign fifo_pop      = (state == S_POP);
   assign m_axis_tvalid = (state == S_SEND);
   assign m_axis_tlast  = (state == S_SEND) && last_beat;
   assign busy          = (state != S_IDLE);
   assign done          = (state == S_DONE);

endmodule

// File: tb/tb_axis_fifo_drain_ctrl.sv
// Bench for axis_fifo_drain_ctrl: queue-based FIFO, beat scoreboard against
// pushed words, directed scenarios plus randomized packets.
module tb_axis_fifo_drain_ctrl;
   localparam int DW = 32;
   localparam int LW = 8;

   logic          clk = 1'b0;
   logic          reset, start, abort, fifo_empty, fifo_pop;
   logic          m_axis_tvalid, m_axis_tready, m_axis_tlast, busy, done, aborted;
   logic [LW-1:0] burst_len;
   logic [DW-1:0] fifo_data, m_axis_tdata;

   int n_cmp = 0, n_bad = 0;
   int done_cnt = 0, abort_cnt = 0, pop_cnt = 0;

   logic [DW-1:0] mem [0:1023];
   int            wr_ptr = 0, rd_ptr = 0;
   logic [DW-1:0] exp_q [$];
   logic [DW-1:0] got_data [$];
   logic          got_last [$];

   logic          pop_q = 1'b0, hold_q = 1'b0, done_q = 1'b0, hold_last;
   logic [DW-1:0] hold_data;

   axis_fifo_drain_ctrl #(.FIFO_DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk(clk), .reset(reset), .start(start), .burst_len(burst_len), .abort(abort),
      .fifo_empty(fifo_empty), .fifo_pop(fifo_pop), .fifo_data(fifo_data),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
      .busy(busy), .done(done), .aborted(aborted)
   );

   always #5 clk = ~clk;

   assign fifo_empty = (wr_ptr == rd_ptr);

   always @(posedge clk) begin
      if (fifo_pop) begin
         fifo_data <= mem[rd_ptr % 1024];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   // protocol watch: sampled mid-cycle, inputs change just after posedge
   always @(negedge clk) begin
      if (!reset) begin
         n_cmp++;
         assert (!(fifo_pop && fifo_empty)) else begin
            n_bad++; $error("FAIL pop_while_empty got=1 want=0");
         end
         n_cmp++;
         assert (!(fifo_pop && pop_q)) else begin
            n_bad++; $error("FAIL pop_two_cycles got=1 want=0");
         end
         n_cmp++;
         assert (!(done && done_q)) else begin
            n_bad++; $error("FAIL done_pulse_width got=2 want=1");
         end
         if (hold_q) begin
            n_cmp++;
            assert (m_axis_tvalid === 1'b1 && m_axis_tdata === hold_data && m_axis_tlast === hold_last)
            else begin
               n_bad++;
               $error("FAIL stall_stable got=%b/%h/%b want=1/%h/%b",
                      m_axis_tvalid, m_axis_tdata, m_axis_tlast, hold_data, hold_last);
            end
         end
         if (m_axis_tvalid && m_axis_tready) begin
            got_data.push_back(m_axis_tdata);
            got_last.push_back(m_axis_tlast);
         end
         if (done)     done_cnt++;
         if (aborted)  abort_cnt++;
         if (fifo_pop) pop_cnt++;
         pop_q     = fifo_pop;
         done_q    = done;
         hold_q    = m_axis_tvalid && !m_axis_tready;
         hold_data = m_axis_tdata;
         hold_last = m_axis_tlast;
      end else begin
         pop_q  = 1'b0;
         done_q = 1'b0;
         hold_q = 1'b0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_cmp++;
      assert (got === want) else begin
         n_bad++;
         $error("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   task automatic push(input logic [DW-1:0] v);
      mem[wr_ptr % 1024] = v;
      wr_ptr = wr_ptr + 1;
      exp_q.push_back(v);
   endtask

   task automatic flush();
      wr_ptr = rd_ptr;
      exp_q.delete();
   endtask

   // compare recorded beats [base, base+n) against the pushed-word order
   task automatic check_beats(input string tag, input int base, input int n, input int last_idx);
      logic [DW-1:0] e;
      for (int i = 0; i < n; i++) begin
         if (base + i < got_data.size() && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, 64'(got_data[base+i]), 64'(e));
            chk({tag, "_last"}, 64'(got_last[base+i]), 64'(i == last_idx));
         end
      end
   endtask

   // rdy_mode: 0 always ready, 1 random, 2 alternating; dbase<0 -> random data
   task automatic run_packet(input string tag, input int n, input int rdy_mode,
                             input bit prefill, input int dbase);
      int base, d0, a0, p0, pending, cyc;
      base = got_data.size(); d0 = done_cnt; a0 = abort_cnt; p0 = pop_cnt;
      pending = prefill ? 0 : n;
      if (prefill)
         for (int i = 0; i < n; i++) push((dbase >= 0) ? DW'(dbase + i) : DW'($urandom));
      burst_len     = LW'(n);
      start         = 1'b1;
      m_axis_tready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      tick();
      start = 1'b0;
      cyc   = 0;
      while (done_cnt == d0 && cyc < 5000) begin
         if (pending > 0 && $urandom_range(0, 2) == 0) begin
            push(DW'($urandom));
            pending--;
         end
         if (rdy_mode == 1) m_axis_tready = 1'($urandom_range(0, 1));
         if (rdy_mode == 2) m_axis_tready = 1'(cyc % 2);
         tick();
         cyc++;
      end
      chk({tag, "_no_timeout"}, 64'(cyc < 5000), 64'd1);
      if (prefill && rdy_mode == 0) chk({tag, "_latency"}, 64'(cyc), 64'(3 * n + 2));
      chk({tag, "_beats"}, 64'(got_data.size() - base), 64'(n));
      check_beats(tag, base, n, n - 1);
      chk({tag, "_pops"}, 64'(pop_cnt - p0), 64'(n));
      tick();
      chk({tag, "_busy_after"}, 64'(busy), 64'd0);
      chk({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
      chk({tag, "_no_abort"}, 64'(abort_cnt - a0), 64'd0);
      m_axis_tready = 1'b0;
   endtask

   initial begin : stim
      int base, d0, a0, p0, cyc;
      reset = 1'b1; start = 1'b0; abort = 1'b0; burst_len = '0; m_axis_tready = 1'b0;
      tick(); tick(); tick();
      chk("rst_busy",  64'(busy), 64'd0);
      chk("rst_done",  64'(done), 64'd0);
      chk("rst_abort", 64'(aborted), 64'd0);
      chk("rst_pop",   64'(fifo_pop), 64'd0);
      chk("rst_valid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_last",  64'(m_axis_tlast), 64'd0);
      chk("rst_tdata", 64'(m_axis_tdata), 64'd0);
      reset = 1'b0;
      tick();

      // preloaded A0..A3, always ready
      run_packet("pkt4", 4, 0, 1'b1, 32'hA0);
      // stalls in SEND
      run_packet("pkt3_toggle", 3, 2, 1'b1, -1);

      // zero-length start is ignored
      d0 = done_cnt; p0 = pop_cnt;
      burst_len = '0; start = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("len0_busy", 64'(busy), 64'd0);
         tick();
      end
      chk("len0_pop",  64'(pop_cnt - p0), 64'd0);
      chk("len0_done", 64'(done_cnt - d0), 64'd0);

      // empty FIFO, late word, abort while waiting for beat 2
      base = got_data.size(); d0 = done_cnt; a0 = abort_cnt; p0 = pop_cnt;
      burst_len = LW'(2); start = 1'b1; m_axis_tready = 1'b1; tick(); start = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      chk("abt_busy_wait", 64'(busy), 64'd1);
      chk("abt_no_pop_yet", 64'(pop_cnt - p0), 64'd0);
      push(32'h5A5A_0001);
      cyc = 0;
      while (got_data.size() <= base && cyc < 50) begin tick(); cyc++; end
      chk("abt_beat_seen", 64'(cyc < 50), 64'd1);
      tick(); tick(); tick();
      chk("abt_in_wait", 64'(busy), 64'd1);
      abort = 1'b1; tick(); abort = 1'b0;
      tick();
      chk("abt_pulse", 64'(abort_cnt - a0), 64'd1);
      chk("abt_no_done", 64'(done_cnt - d0), 64'd0);
      chk("abt_idle", 64'(busy), 64'd0);
      check_beats("abt", base, 1, -1);
      chk("abt_one_beat", 64'(got_data.size() - base), 64'd1);
      push(32'h5A5A_0002);
      for (int i = 0; i < 5; i++) tick();
      chk("abt_no_more_pop", 64'(pop_cnt - p0), 64'd1);
      flush();
      m_axis_tready = 1'b0;

      // reset while beat 2 of 4 is presented
      base = got_data.size(); d0 = done_cnt; a0 = abort_cnt;
      for (int i = 0; i < 4; i++) push(DW'(32'hC0 + i));
      burst_len = LW'(4); start = 1'b1; m_axis_tready = 1'b1; tick(); start = 1'b0;
      cyc = 0;
      while (got_data.size() <= base && cyc < 50) begin tick(); cyc++; end
      m_axis_tready = 1'b0;
      while (!m_axis_tvalid && cyc < 100) begin tick(); cyc++; end
      chk("rmid_in_send", 64'(m_axis_tvalid), 64'd1);
      reset = 1'b1;
      #1;
      chk("rmid_valid", 64'(m_axis_tvalid), 64'd0);
      chk("rmid_last",  64'(m_axis_tlast), 64'd0);
      chk("rmid_busy",  64'(busy), 64'd0);
      chk("rmid_tdata", 64'(m_axis_tdata), 64'd0);
      chk("rmid_pop",   64'(fifo_pop), 64'd0);
      check_beats("rmid", base, 1, -1);
      tick(); tick();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) tick();
      chk("rmid_no_done",  64'(done_cnt - d0), 64'd0);
      chk("rmid_no_abort", 64'(abort_cnt - a0), 64'd0);
      flush();
      run_packet("post_rst", 1, 0, 1'b1, -1);

      // max length, random ready
      run_packet("len_max", 255, 1, 1'b1, -1);

      // randomized packets: late pushes and random backpressure
      for (int k = 0; k < 8; k++)
         run_packet("rand", int'($urandom_range(1, 12)), int'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), -1);

      // start while busy is ignored: one packet, not two
      d0 = done_cnt; base = got_data.size();
      for (int i = 0; i < 2; i++) push(DW'(32'hE0 + i));
      burst_len = LW'(2); start = 1'b1; m_axis_tready = 1'b1; tick();
      burst_len = LW'(5); tick(); tick(); start = 1'b0;
      cyc = 0;
      while (done_cnt == d0 && cyc < 100) begin tick(); cyc++; end
      tick(); tick();
      chk("busy_start_beats", 64'(got_data.size() - base), 64'd2);
      check_beats("busy_start", base, 2, 1);
      chk("busy_start_idle", 64'(busy), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
